gbus_rr_controller: RTL and testbench

Parametrised global-bus controller: arbitrates `NUM_PORTS` core requesters onto one registered global-bus packet stream. It uses round-robin priority, burst locking and downstream backpressure. It sits between the per-core bus request ports and the global-bus fabric. Compared with the fixed 16-port, fixed-priority controller, it adds configurable packet field widths, fair arbitration, multi-beat bursts, a `bus_ready` handshake and a `vld` that is exactly aligned to the data it qualifies.

---
 rtl/gbus_rr_controller_pkg.sv | 37 +++
 rtl/gbus_rr_controller_if.sv | 28 ++
 rtl/gbus_rr_controller_rr_arbiter.sv | 33 +++
 rtl/gbus_rr_controller.sv | 126 ++++++++++++
 tb/tb_gbus_rr_controller.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/gbus_rr_controller_pkg.sv
// Shared definitions for the global-bus controller: default field widths,
// packet layout, arbiter states and the IDLE packet pattern.
package gbus_pkg;

  localparam int unsigned GBUS_DATA_W      = 32;
  localparam int unsigned GBUS_CMEM_ADDR_W = 13;
  localparam int unsigned GBUS_CORE_ADDR_W = 4;
  localparam int unsigned GBUS_HEAD_BIAS_W = 2;
  localparam int unsigned GBUS_PKT_W       = GBUS_DATA_W + GBUS_HEAD_BIAS_W
                                           + GBUS_CORE_ADDR_W + GBUS_CMEM_ADDR_W;

  // Field offsets for the default layout (MSB->LSB: data, bias, core, cmem)
  localparam int unsigned GBUS_CMEM_LSB = 0;
  localparam int unsigned GBUS_CORE_LSB = GBUS_CMEM_LSB + GBUS_CMEM_ADDR_W;
  localparam int unsigned GBUS_BIAS_LSB = GBUS_CORE_LSB + GBUS_CORE_ADDR_W;
  localparam int unsigned GBUS_DATA_LSB = GBUS_BIAS_LSB + GBUS_HEAD_BIAS_W;

  // Upper bound on packet width handled by idle_packet(); callers truncate.
  localparam int unsigned GBUS_MAX_PKT_W = 512;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // IDLE packet: core field all ones, every other field zero.
  function automatic logic [GBUS_MAX_PKT_W-1:0] idle_packet(input int unsigned core_lsb,
                                                            input int unsigned core_w);
    logic [GBUS_MAX_PKT_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < core_w; i++) begin
      p[core_lsb + i] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/gbus_rr_controller_if.sv
// Request/grant and bus-packet signals between the core ports, the
// controller and the global-bus fabric.
interface gbus_rr_controller_if #(
  parameter int unsigned NUM_PORTS = 16,
  parameter int unsigned PKT_W     = gbus_pkg::GBUS_PKT_W,
  parameter int unsigned ID_W      = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS*PKT_W-1:0] in_packet_array;
  logic [NUM_PORTS-1:0]       req_array;
  logic [NUM_PORTS-1:0]       last_array;
  logic [NUM_PORTS-1:0]       grant_array;
  logic [ID_W-1:0]            owner_id;
  logic [PKT_W-1:0]           bus_packet;
  logic                       bus_packet_vld;
  logic                       bus_ready;

  // Controller side
  modport master (
    input  in_packet_array, req_array, last_array, bus_ready,
    output grant_array, owner_id, bus_packet, bus_packet_vld
  );

  // Requesters and fabric side
  modport slave (
    output in_packet_array, req_array, last_array, bus_ready,
    input  grant_array, owner_id, bus_packet, bus_packet_vld
  );
endinterface

// File: rtl/gbus_rr_controller_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or above ptr
// wins, wrapping around, via a double-width masked priority search.
module rr_arbiter #(
  parameter  int unsigned NUM_PORTS = 16,
  localparam int unsigned ID_W      = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [ID_W-1:0]      gnt_id
);

  logic [NUM_PORTS-1:0]   masked;
  logic [2*NUM_PORTS-1:0] dbl;
  logic                   found;

  // Lower half holds requests at or above ptr; upper half is the wrapped copy.
  always_comb begin
    masked = req & ({NUM_PORTS{1'b1}} << ptr);
    dbl    = {req, masked};
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < 2*NUM_PORTS; k++) begin
      if (!found && dbl[k]) begin
        found                 = 1'b1;
        gnt_id                = ID_W'(k % NUM_PORTS);
        gnt[k % NUM_PORTS]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gbus_rr_controller.sv
// Global-bus controller: round-robin arbitration with burst locking onto a
// registered, backpressured packet stream.
module gbus_rr_controller
  import gbus_pkg::*;
#(
  parameter  int unsigned NUM_PORTS   = 16,
  parameter  int unsigned DATA_W      = GBUS_DATA_W,
  parameter  int unsigned CMEM_ADDR_W = GBUS_CMEM_ADDR_W,
  parameter  int unsigned CORE_ADDR_W = GBUS_CORE_ADDR_W,
  parameter  int unsigned HEAD_BIAS_W = GBUS_HEAD_BIAS_W,
  parameter  int unsigned MAX_BURST   = 8,
  localparam int unsigned PKT_W       = DATA_W + HEAD_BIAS_W + CORE_ADDR_W + CMEM_ADDR_W,
  localparam int unsigned ID_W        = $clog2(NUM_PORTS),
  localparam int unsigned BEAT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input logic             clk,
  input logic             rst_n,
  gbus_rr_controller_if.master bus
);

  localparam logic [GBUS_MAX_PKT_W-1:0] IDLE_WIDE = idle_packet(CMEM_ADDR_W, CORE_ADDR_W);
  localparam logic [PKT_W-1:0]          IDLE_PKT  = IDLE_WIDE[PKT_W-1:0];

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [BEAT_W-1:0]    beat_cnt, beat_cnt_d;
  logic [PKT_W-1:0]     pkt_q, pkt_d;
  logic                 vld_q, vld_d;

  logic                 accept, locked, hold_req, hold_last, xfer, burst_end, release_h;
  logic [ID_W-1:0]      next_ptr, arb_ptr, arb_id;
  logic [NUM_PORTS-1:0] arb_gnt;
  logic [PKT_W-1:0]     hold_pkt;

  assign accept    = bus.bus_ready | ~vld_q;
  assign locked    = (state_q == ARB_LOCKED);
  assign hold_req  = bus.req_array[owner_q];
  assign hold_last = bus.last_array[owner_q];
  assign hold_pkt  = bus.in_packet_array[owner_q*PKT_W +: PKT_W];
  assign xfer      = locked & hold_req & accept;
  assign burst_end = (beat_cnt == BEAT_W'(MAX_BURST - 1));
  assign release_h = locked & (~hold_req | (xfer & (hold_last | burst_end)));
  assign next_ptr  = (owner_q == ID_W'(NUM_PORTS - 1)) ? '0 : owner_q + ID_W'(1);
  // Re-arbitrate with the post-release pointer in the release cycle: no bubble.
  assign arb_ptr   = release_h ? next_ptr : ptr_q;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req    (bus.req_array),
    .ptr    (arb_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt;
    pkt_d      = pkt_q;
    vld_d      = vld_q;

    if (xfer) begin
      pkt_d      = hold_pkt;
      vld_d      = 1'b1;
      beat_cnt_d = beat_cnt + BEAT_W'(1);
    end else if (accept) begin
      pkt_d = IDLE_PKT;
      vld_d = 1'b0;
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (|bus.req_array) begin
          state_d    = ARB_LOCKED;
          grant_d    = arb_gnt;
          owner_d    = arb_id;
          beat_cnt_d = '0;
        end
      end
      ARB_LOCKED: begin
        if (release_h) begin
          ptr_d      = next_ptr;
          beat_cnt_d = '0;
          if (|bus.req_array) begin
            grant_d = arb_gnt;
            owner_d = arb_id;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
            owner_d = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      beat_cnt <= '0;
      pkt_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      beat_cnt <= beat_cnt_d;
      pkt_q    <= pkt_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.grant_array    = grant_q;
  assign bus.owner_id       = owner_q;
  assign bus.bus_packet     = pkt_q;
  assign bus.bus_packet_vld = vld_q;

endmodule

// File: tb/tb_gbus_rr_controller.sv
// Directed bench for gbus_rr_controller: reset, single request, round-robin,
// burst cap, backpressure, abandon and asynchronous reset mid-burst.
module tb_gbus_rr_controller;

  localparam int unsigned N     = 16;
  localparam int unsigned PKT_W = 51;
  localparam int unsigned ID_W  = 4;
  localparam logic [PKT_W-1:0] IDLE_P = {32'd0, 2'd0, 4'hF, 13'd0};

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  gbus_rr_controller_if #(.NUM_PORTS(N), .PKT_W(PKT_W), .ID_W(ID_W)) bus_if ();

  gbus_rr_controller #(
    .NUM_PORTS   (N),
    .DATA_W      (32),
    .CMEM_ADDR_W (13),
    .CORE_ADDR_W (4),
    .HEAD_BIAS_W (2),
    .MAX_BURST   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  function automatic logic [PKT_W-1:0] mkpkt(input int p, input int n);
    return {32'(32'hC0DE_0000 + p*256 + n), 2'(n), 4'(p), 13'(p*64 + n)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_bus(input string tag, input int own,
                            input logic [PKT_W-1:0] pkt, input logic vld);
    chk({tag, ".grant"}, 64'(bus_if.grant_array), (own < 0) ? 64'd0 : (64'd1 << own));
    chk({tag, ".owner"}, 64'(bus_if.owner_id),    (own < 0) ? 64'd0 : 64'(own));
    chk({tag, ".pkt"},   64'(bus_if.bus_packet),  64'(pkt));
    chk({tag, ".vld"},   64'(bus_if.bus_packet_vld), 64'(vld));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic r, input logic l, input logic [PKT_W-1:0] v);
    bus_if.req_array[p]  = r;
    bus_if.last_array[p] = l;
    bus_if.in_packet_array[p*PKT_W +: PKT_W] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n                  = 1'b0;
    bus_if.bus_ready       = 1'b1;
    bus_if.req_array       = '0;
    bus_if.last_array      = '0;
    bus_if.in_packet_array = '0;

    // Reset values, then IDLE pattern from the first accept cycle
    #1;
    expect_bus("reset", -1, '0, 1'b0);
    chk("reset.beat", 64'(dut.beat_cnt), 64'd0);
    #6 rst_n = 1'b1;
    tick();
    expect_bus("idle_load", -1, IDLE_P, 1'b0);

    // Single request from port 5
    put(5, 1'b1, 1'b1, mkpkt(5, 0));
    tick(); expect_bus("single.grant", 5, IDLE_P, 1'b0);
    tick(); expect_bus("single.data", 5, mkpkt(5, 0), 1'b1);
    put(5, 1'b0, 1'b0, '0);
    tick(); expect_bus("single.idle", -1, IDLE_P, 1'b0);

    // Round-robin across ports 0, 3, 15 with zero-gap handover
    do_reset();
    put(0, 1'b1, 1'b1, mkpkt(0, 0));
    put(3, 1'b1, 1'b1, mkpkt(3, 0));
    put(15, 1'b1, 1'b1, mkpkt(15, 0));
    tick(); expect_bus("rr0", 0, IDLE_P, 1'b0);
    tick(); expect_bus("rr1", 3, mkpkt(0, 0), 1'b1);
    tick(); expect_bus("rr2", 15, mkpkt(3, 0), 1'b1);
    tick(); expect_bus("rr3", 0, mkpkt(15, 0), 1'b1);
    tick(); expect_bus("rr4", 3, mkpkt(0, 0), 1'b1);
    put(0, 1'b0, 1'b0, '0);
    put(3, 1'b0, 1'b0, '0);
    put(15, 1'b0, 1'b0, '0);
    tick(); expect_bus("rr_end", -1, IDLE_P, 1'b0);

    // Burst cap: port 2 gets 8 beats, then port 7, then port 2 resumes
    do_reset();
    put(7, 1'b1, 1'b1, mkpkt(7, 0));
    put(2, 1'b1, 1'b0, mkpkt(2, 0));
    tick(); expect_bus("burst.grant", 2, IDLE_P, 1'b0);
    for (int j = 0; j < 8; j++) begin
      tick();
      expect_bus($sformatf("burst.b%0d", j), (j == 7) ? 7 : 2, mkpkt(2, j), 1'b1);
      put(2, 1'b1, 1'b0, mkpkt(2, j + 1));
    end
    tick(); expect_bus("burst.p7", 2, mkpkt(7, 0), 1'b1);
    put(7, 1'b0, 1'b0, '0);
    tick(); expect_bus("burst.resume", 2, mkpkt(2, 8), 1'b1);
    chk("burst.resume.beat", 64'(dut.beat_cnt), 64'd1);
    put(2, 1'b1, 1'b0, mkpkt(2, 9));

    // Backpressure: three stalled cycles, then the burst continues intact
    bus_if.bus_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_bus($sformatf("bp.hold%0d", k), 2, mkpkt(2, 8), 1'b1);
      chk($sformatf("bp.hold%0d.beat", k), 64'(dut.beat_cnt), 64'd1);
    end
    bus_if.bus_ready = 1'b1;
    tick(); expect_bus("bp.b9", 2, mkpkt(2, 9), 1'b1);
    put(2, 1'b1, 1'b0, mkpkt(2, 10));
    tick(); expect_bus("bp.b10", 2, mkpkt(2, 10), 1'b1);
    put(2, 1'b1, 1'b1, mkpkt(2, 11));
    tick(); expect_bus("bp.b11", 2, mkpkt(2, 11), 1'b1);
    put(2, 1'b0, 1'b0, '0);
    tick(); expect_bus("bp.end", -1, IDLE_P, 1'b0);

    // Abandon: port 4 drops req mid-burst, grant moves to port 9
    put(4, 1'b1, 1'b0, mkpkt(4, 0));
    put(9, 1'b1, 1'b0, mkpkt(9, 0));
    tick(); expect_bus("ab.grant", 4, IDLE_P, 1'b0);
    tick(); expect_bus("ab.beat", 4, mkpkt(4, 0), 1'b1);
    chk("ab.beat.cnt", 64'(dut.beat_cnt), 64'd1);
    put(4, 1'b0, 1'b0, '0);
    tick(); expect_bus("ab.move", 9, IDLE_P, 1'b0);
    chk("ab.move.cnt", 64'(dut.beat_cnt), 64'd0);

    // Asynchronous reset mid-burst; arbitration restarts from port 0
    tick(); expect_bus("rst.pre", 9, mkpkt(9, 0), 1'b1);
    put(3, 1'b1, 1'b0, mkpkt(3, 0));
    #2 rst_n = 1'b0;
    #1;
    expect_bus("rst.async", -1, '0, 1'b0);
    chk("rst.async.beat", 64'(dut.beat_cnt), 64'd0);
    rst_n = 1'b1;
    tick(); expect_bus("rst.restart", 3, IDLE_P, 1'b0);

    if (n_fail > 0) $display("%0d comparisons reported errors", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
